// File: rtl/traffic_request_conditioner_if.sv
// Raw sensor/button inputs, controller walk feedback and the
// conditioned requests handed to the traffic light controller.
interface traffic_request_conditioner_if #(
  parameter int WAIT_W = 8
);
  logic              sensor_ns_raw;
  logic              sensor_ew_raw;
  logic              ped_btn_raw;
  logic              walk_signal;
  logic              car_ns;
  logic              car_ew;
  logic              ped_button;
  logic [WAIT_W-1:0] ped_wait_cnt;

  modport master (
    output sensor_ns_raw,
    output sensor_ew_raw,
    output ped_btn_raw,
    output walk_signal,
    input  car_ns,
    input  car_ew,
    input  ped_button,
    input  ped_wait_cnt
  );

  modport slave (
    input  sensor_ns_raw,
    input  sensor_ew_raw,
    input  ped_btn_raw,
    input  walk_signal,
    output car_ns,
    output car_ew,
    output ped_button,
    output ped_wait_cnt
  );
endinterface

// File: rtl/traffic_request_conditioner.sv
// Synchronise, debounce and gap-extend car loops; latch pedestrian
// presses until the controller grants walk.
module traffic_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CAR_HOLD_CYCLES = 3,
  parameter int WAIT_W          = 8
) (
  input logic clk,
  input logic rst_n,
  traffic_request_conditioner_if.slave bus
);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD    = 8'(CAR_HOLD_CYCLES);

  typedef enum logic [1:0] {
    P_IDLE,
    P_PENDING,
    P_SERVING
  } ped_state_t;

  // channel order: 0 = NS, 1 = EW, 2 = pedestrian
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      stable;
  logic [2:0]      take;
  logic [2:0][7:0] db_cnt;
  logic [1:0][7:0] hold;
  logic [1:0]      car;
  logic            press;
  logic            ped_q;
  ped_state_t      state;
  ped_state_t      state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  assign raw = {bus.ped_btn_raw, bus.sensor_ew_raw, bus.sensor_ns_raw};

  always_comb begin
    take = '0;
    for (int i = 0; i < 3; i++) begin
      take[i] = (sync2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (take[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // hold loads on the falling accept edge, clears on the rising one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold  <= '0;
      car   <= '0;
      press <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (take[i]) begin
          hold[i] <= stable[i] ? HOLD : 8'd0;
        end else if (!stable[i] && hold[i] != 8'd0) begin
          hold[i] <= hold[i] - 8'd1;
        end
        car[i] <= stable[i] | (hold[i] != 8'd0);
      end
      press <= take[2] & ~stable[2];
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      P_IDLE: begin
        wait_nxt = '0;
        if (press && !bus.walk_signal) begin
          state_nxt = P_PENDING;
        end
      end
      P_PENDING: begin
        if (wait_cnt != '1) begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
        if (bus.walk_signal) begin
          state_nxt = P_SERVING;
        end
      end
      P_SERVING: begin
        if (!bus.walk_signal) begin
          state_nxt = P_IDLE;
          wait_nxt  = '0;
        end
      end
      default: begin
        state_nxt = P_IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= P_IDLE;
      wait_cnt <= '0;
      ped_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ped_q    <= (state_nxt == P_PENDING);
    end
  end

  assign bus.car_ns       = car[0];
  assign bus.car_ew       = car[1];
  assign bus.ped_button   = ped_q;
  assign bus.ped_wait_cnt = wait_cnt;
endmodule
